pmem_line_buffer: RTL and testbench
===================================

// Module: pmem_line_buffer
// PURPOSE
//  Initiator side of the 128-bit physical-memory protocol: one-entry write-back line buffer.
//  Sits between the CPU's 16-bit word port and the physical memory block.
//  Turns CPU word reads and writes into line fills and line writebacks on the pmem port.
// PARAMETERS
//  ADDR_W  16   byte address width, shared by the CPU and pmem ports
//  WORD_W  16   CPU data width; byte enables = WORD_W/8
//  LINE_W  128  line width; offset bits = log2(LINE_W/8) = 4
// PORTS
//  clk              in   1       sole clock, rising edge
//  rst_n            in   1       asynchronous, active-low reset
//  mem_read         in   1       CPU read request; held until mem_resp
//  mem_write        in   1       CPU write request; held until mem_resp
//  mem_byte_enable  in   2       byte lanes of mem_wdata to write
//  mem_address      in   16      byte address; bit 0 ignored
//  mem_wdata        in   16      CPU write data
//  mem_rdata        out  16      read data, valid while mem_resp=1
//  mem_resp         out  1       one-cycle completion pulse
//  pmem_read        out  1       line read request
//  pmem_write       out  1       line write request
//  pmem_address     out  16      line address, bits [3:0] always 0
//  pmem_wdata       out  128     line writeback data
//  pmem_rdata       in   128     fill data, sampled when pmem_resp=1
//  pmem_resp        in   1       memory completion pulse
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   state=IDLE; valid=0; dirty=0; tag=0; line=0.
//   All outputs 0. Any in-flight pmem transaction is abandoned; dirty data is lost.
//  Address split: tag=addr[15:4]; word=addr[3:1]; line word w occupies bits [16w+15:16w].
//  State machine (registered state; all outputs Moore-decoded from registers):
//   IDLE:
//    - No request: stay.
//    - Request: latch op, address, wdata and byte enables.
//    - hit = valid && tag==req tag. Hit -> APPLY.
//    - Miss with valid && dirty -> WRITEBACK.
//    - Miss otherwise -> FILL.
//    - mem_read and mem_write both high: treat as write.
//   WRITEBACK:
//    - pmem_write=1, pmem_address={tag,4'h0}, pmem_wdata=line.
//    - On pmem_resp: dirty=0, go to FILL.
//   FILL:
//    - pmem_read=1, pmem_address={req tag,4'h0}.
//    - On pmem_resp: line=pmem_rdata, tag=req tag, valid=1, dirty=0, go to APPLY.
//   APPLY:
//    - Write: merge enabled bytes into the selected word; dirty=1.
//    - Read: capture the selected word into mem_rdata.
//    - Always go to RESPOND.
//   RESPOND: mem_resp=1 for exactly this one cycle, then IDLE.
//  Latency from the request-sampling edge to mem_resp high:
//   - hit: 2 cycles.
//   - miss: 2 cycles + fill time (+ writeback time if the line is dirty).
//  Pmem handshake rules:
//   - pmem_read and pmem_write are never high together.
//   - Each is held constant until pmem_resp is sampled high.
//   - Each drops in the cycle after pmem_resp is sampled, so the memory sees it low on its return to idle.
//   - pmem_resp is ignored outside WRITEBACK and FILL.
//  CPU-side rules:
//   - Request inputs are sampled only in IDLE; changes while busy are ignored.
//   - The CPU drops its request after seeing mem_resp; RESPOND->IDLE guarantees no double issue.
//  Boundary cases:
//   - byte_enable=2'b00 write: line data unchanged, but dirty is still set.
//   - Address 16'hFFFF: tag 12'hFFF, word 7; no wrap.
//   - Reset asserted mid-WRITEBACK or mid-FILL: outputs fall immediately; the next access misses.
// STRUCTURE
//  Package pmem_line_buffer_pkg holds:
//   - lb_state_t enum {IDLE, WRITEBACK, FILL, APPLY, RESPOND}
//   - localparams OFFSET_W, TAG_W, WORDS_PER_LINE
//  Sub-module line_word_merge (combinational):
//   - inputs: line, word index, wdata, byte enables
//   - outputs: merged line and selected read word
// TESTING
//  - Reset then read 16'h0010 with memory line 1 = 128'h...0007_0006_0005_0004_0003_0002_0001_0000
//    -> one FILL (pmem_address 16'h0010), mem_rdata=16'h0000, no WRITEBACK.
//  - Read 16'h001E right after -> hit, mem_resp exactly 2 cycles after sampling, rdata 16'h0007, pmem idle.
//  - Write 16'h0012 data 16'hBEEF be=2'b01, then read it -> 16'h00EF, dirty=1.
//  - Then read 16'h0020 -> WRITEBACK to 16'h0010 with word1=16'h00EF, then FILL of 16'h0020;
//    pmem_read/pmem_write never overlap.
//  - Assert rst_n=0 while in FILL -> pmem_read=0 at once; re-read 16'h0010 misses again, no WRITEBACK.
//  - Memory with DELAY_MEM>0, CPU holding mem_read high through RESPOND
//    -> exactly one mem_resp pulse per request, exactly one pmem transaction per miss.

Source files
------------

// File: rtl/pmem_line_buffer_pkg.sv
// Shared types and geometry for the one-entry write-back line buffer.
package pmem_line_buffer_pkg;

    localparam int unsigned LB_ADDR_W      = 16;
    localparam int unsigned LB_WORD_W      = 16;
    localparam int unsigned LB_LINE_W      = 128;
    localparam int unsigned OFFSET_W       = $clog2(LB_LINE_W / 8);
    localparam int unsigned TAG_W          = LB_ADDR_W - OFFSET_W;
    localparam int unsigned WORDS_PER_LINE = LB_LINE_W / LB_WORD_W;

    typedef enum logic [2:0] {
        IDLE,
        WRITEBACK,
        FILL,
        APPLY,
        RESPOND
    } lb_state_t;

endpackage

// File: rtl/line_word_merge.sv
// Combinational word select and byte-lane merge into a cache line.
module line_word_merge
    import pmem_line_buffer_pkg::*;
#(
    parameter int unsigned LINE_W = LB_LINE_W,
    parameter int unsigned WORD_W = LB_WORD_W
) (
    input  logic [LINE_W-1:0]                line,
    input  logic [$clog2(LINE_W/WORD_W)-1:0] word_idx,
    input  logic [WORD_W-1:0]                wdata,
    input  logic [WORD_W/8-1:0]              byte_en,
    output logic [LINE_W-1:0]                merged_line,
    output logic [WORD_W-1:0]                rd_word
);

    localparam int unsigned WORDS = LINE_W / WORD_W;
    localparam int unsigned BYTES = WORD_W / 8;

    always_comb begin
        merged_line = line;
        rd_word     = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (w == 32'(word_idx)) begin
                rd_word = line[w*WORD_W +: WORD_W];
                for (int unsigned b = 0; b < BYTES; b++) begin
                    if (byte_en[b]) begin
                        merged_line[w*WORD_W + b*8 +: 8] = wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pmem_line_buffer.sv
// One-entry write-back line buffer between a 16-bit CPU word port and a 128-bit pmem port.
module pmem_line_buffer
    import pmem_line_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W = LB_ADDR_W,
    parameter int unsigned WORD_W = LB_WORD_W,
    parameter int unsigned LINE_W = LB_LINE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [WORD_W/8-1:0] mem_byte_enable,
    input  logic [ADDR_W-1:0]   mem_address,
    input  logic [WORD_W-1:0]   mem_wdata,
    output logic [WORD_W-1:0]   mem_rdata,
    output logic                mem_resp,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [ADDR_W-1:0]   pmem_address,
    output logic [LINE_W-1:0]   pmem_wdata,
    input  logic [LINE_W-1:0]   pmem_rdata,
    input  logic                pmem_resp
);

    localparam int unsigned OFF_W = $clog2(LINE_W / 8);
    localparam int unsigned IDX_W = $clog2(LINE_W / WORD_W);
    localparam int unsigned TG_W  = ADDR_W - OFF_W;
    localparam int unsigned BE_W  = WORD_W / 8;

    lb_state_t            state, state_nxt;
    logic                 valid, dirty;
    logic [TG_W-1:0]      tag, req_tag;
    logic [IDX_W-1:0]     req_word;
    logic                 req_wr;
    logic [WORD_W-1:0]    req_wdata, rdata_q, sel_word;
    logic [BE_W-1:0]      req_be;
    logic [LINE_W-1:0]    line, merged_line;
    logic                 req_any, hit;
    logic [TG_W-1:0]      addr_tag;
    logic                 unused_addr_lsb;

    assign req_any         = mem_read | mem_write;
    assign addr_tag        = mem_address[ADDR_W-1:OFF_W];
    assign hit             = valid && (tag == addr_tag);
    assign unused_addr_lsb = mem_address[0];

    line_word_merge #(
        .LINE_W (LINE_W),
        .WORD_W (WORD_W)
    ) u_merge (
        .line        (line),
        .word_idx    (req_word),
        .wdata       (req_wdata),
        .byte_en     (req_be),
        .merged_line (merged_line),
        .rd_word     (sel_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_any) begin
                    if (hit)                state_nxt = APPLY;
                    else if (valid && dirty) state_nxt = WRITEBACK;
                    else                    state_nxt = FILL;
                end
            end
            WRITEBACK: if (pmem_resp) state_nxt = FILL;
            FILL:      if (pmem_resp) state_nxt = APPLY;
            APPLY:     state_nxt = RESPOND;
            RESPOND:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // A simultaneous read and write is latched as a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= 1'b0;
            dirty     <= 1'b0;
            tag       <= '0;
            line      <= '0;
            req_wr    <= 1'b0;
            req_tag   <= '0;
            req_word  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        req_wr    <= mem_write;
                        req_tag   <= addr_tag;
                        req_word  <= mem_address[OFF_W-1 -: IDX_W];
                        req_wdata <= mem_wdata;
                        req_be    <= mem_byte_enable;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) dirty <= 1'b0;
                end
                FILL: begin
                    if (pmem_resp) begin
                        line  <= pmem_rdata;
                        tag   <= req_tag;
                        valid <= 1'b1;
                        dirty <= 1'b0;
                    end
                end
                APPLY: begin
                    if (req_wr) begin
                        line  <= merged_line;
                        dirty <= 1'b1;
                    end else begin
                        rdata_q <= sel_word;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_resp   = (state == RESPOND);
    assign mem_rdata  = rdata_q;
    assign pmem_read  = (state == FILL);
    assign pmem_write = (state == WRITEBACK);
    assign pmem_wdata = (state == WRITEBACK) ? line : '0;

    always_comb begin
        pmem_address = '0;
        if (state == WRITEBACK) pmem_address = {tag, {OFF_W{1'b0}}};
        else if (state == FILL) pmem_address = {req_tag, {OFF_W{1'b0}}};
    end

endmodule

// File: tb/tb_pmem_line_buffer.sv
// Self-checking bench: fixed vector table, reset/hold corner sequences, random traffic vs. a flat-memory model.
module tb_pmem_line_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read, mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address, mem_wdata, mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;

    always #5 clk = ~clk;

    pmem_line_buffer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    int total = 0;
    int bad   = 0;
    int delay_mem = 0;
    int n_rd = 0;
    int n_wr = 0;
    logic [15:0] last_wb_addr = '0;
    logic [15:0] last_fill_addr = '0;

    // Backing memory (what pmem holds) and the CPU-visible flat word view.
    logic [127:0] mem_line [4096];
    logic [15:0]  ref_mem  [32768];
    bit           m_valid, m_dirty;
    logic [11:0]  m_tag;

    function automatic logic [15:0] pat_word(input logic [11:0] t, input int w);
        return {t - 12'd1, 4'(w)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: answers after delay_mem idle cycles, one pulse per request.
    initial begin
        int cnt;
        logic [127:0] e;
        cnt = 0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pmem_resp = 1'b0;
                cnt = 0;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
                cnt = 0;
            end else if (pmem_read || pmem_write) begin
                if (cnt >= delay_mem) begin
                    if (pmem_write) begin
                        for (int w = 0; w < 8; w++)
                            e[16*w +: 16] = ref_mem[{pmem_address[15:4], 3'(w)}];
                        check("wb_data", pmem_wdata, e);
                        mem_line[pmem_address[15:4]] = pmem_wdata;
                        last_wb_addr = pmem_address;
                        n_wr++;
                    end else begin
                        pmem_rdata = mem_line[pmem_address[15:4]];
                        last_fill_addr = pmem_address;
                        n_rd++;
                    end
                    pmem_resp = 1'b1;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Protocol monitor: values the DUT saw at the edge vs. what it shows afterwards.
    logic rd_e = 1'b0, wr_e = 1'b0, rs_e = 1'b0, rst_e = 1'b0, resp_prev = 1'b0;
    always @(posedge clk) begin
        rd_e  <= pmem_read;
        wr_e  <= pmem_write;
        rs_e  <= pmem_resp;
        rst_e <= rst_n;
    end
    always @(negedge clk) begin
        if (pmem_read || pmem_write) check("pmem_overlap", pmem_read & pmem_write, 1'b0);
        if (rst_n && rst_e) begin
            if (rd_e) check("pmem_read_hold", pmem_read, !rs_e);
            if (wr_e) check("pmem_write_hold", pmem_write, !rs_e);
        end
        if (resp_prev) check("mem_resp_pulse", mem_resp, 1'b0);
        resp_prev <= mem_resp;
    end

    task automatic model_update(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                                input logic [1:0] be);
        if (!(m_valid && m_tag == addr[15:4])) begin
            m_valid = 1'b1;
            m_tag   = addr[15:4];
            m_dirty = 1'b0;
        end
        if (wr) begin
            if (be[0]) ref_mem[addr[15:1]][7:0]  = wd[7:0];
            if (be[1]) ref_mem[addr[15:1]][15:8] = wd[15:8];
            m_dirty = 1'b1;
        end
    endtask

    task automatic model_reset();
        if (m_valid && m_dirty)
            for (int w = 0; w < 8; w++)
                ref_mem[{m_tag, 3'(w)}] = mem_line[m_tag][16*w +: 16];
        m_valid = 1'b0;
        m_dirty = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic access(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                          input logic [1:0] be, input bit hold, output logic [15:0] rdata,
                          output int lat, output int drd, output int dwr);
        int r0, w0;
        bit got;
        r0 = n_rd;
        w0 = n_wr;
        @(negedge clk);
        mem_read = rd;
        mem_write = wr;
        mem_address = addr;
        mem_wdata = wd;
        mem_byte_enable = be;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (mem_resp) got = 1'b1;
        end
        rdata = mem_rdata;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: no mem_resp within %0d cycles for addr %h", lat, addr);
            lat = -1;
        end
        if (hold) begin
            @(negedge clk);
            check("hold_resp_once", mem_resp, 1'b0);
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        if (hold) begin
            @(negedge clk);
            check("hold_no_reissue", mem_resp, 1'b0);
        end
        drd = n_rd - r0;
        dwr = n_wr - w0;
    endtask

    task automatic run_model(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                             input logic [1:0] be, input bit hold);
        bit hit, wb;
        logic [15:0] exp_rd, got;
        int lat, drd, dwr, exp_lat;
        hit = m_valid && (m_tag == addr[15:4]);
        wb  = !hit && m_valid && m_dirty;
        exp_rd = ref_mem[addr[15:1]];
        exp_lat = hit ? 2 : (wb ? 2*delay_mem + 5 : delay_mem + 3);
        access(rd, wr, addr, wd, be, hold, got, lat, drd, dwr);
        check("latency", lat, exp_lat);
        check("fill_count", drd, hit ? 0 : 1);
        check("wb_count", dwr, wb ? 1 : 0);
        if (wb)   check("wb_addr", last_wb_addr, {m_tag, 4'h0});
        if (!hit) check("fill_addr", last_fill_addr, {addr[15:4], 4'h0});
        if (!wr)  check("rdata", got, exp_rd);
        model_update(wr, addr, wd, be);
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [1:0]  be;
        bit          exp_hit;
        bit          exp_wb;
        logic [15:0] wb_addr;
        logic [15:0] fill_addr;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [15:0] got, a;
        int lat, drd, dwr, exp_lat;
        bit r, w;

        tbl[0]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 16'h001E, 16'h0000, 2'b11, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0007};
        tbl[2]  = '{1'b0, 1'b1, 16'h0012, 16'hBEEF, 2'b01, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b1, 1'b0, 16'h0012, 16'h0000, 2'b11, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h00EF};
        tbl[4]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b11, 1'b0, 1'b1, 16'h0010, 16'h0020, 16'h0010};
        tbl[5]  = '{1'b0, 1'b1, 16'hFFFF, 16'hA55A, 2'b10, 1'b0, 1'b0, 16'h0000, 16'hFFF0, 16'h0000};
        tbl[6]  = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 2'b11, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hA5E7};
        tbl[7]  = '{1'b0, 1'b1, 16'h0020, 16'h1234, 2'b00, 1'b0, 1'b1, 16'hFFF0, 16'h0020, 16'h0000};
        tbl[8]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, 1'b0, 1'b1, 16'h0020, 16'h0010, 16'h0000};
        tbl[9]  = '{1'b1, 1'b0, 16'h0012, 16'h0000, 2'b11, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h00EF};
        tbl[10] = '{1'b1, 1'b1, 16'h0014, 16'h5A5A, 2'b11, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        tbl[11] = '{1'b1, 1'b0, 16'h0014, 16'h0000, 2'b11, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h5A5A};
        tbl[12] = '{1'b1, 1'b0, 16'h0022, 16'h0000, 2'b11, 1'b0, 1'b1, 16'h0010, 16'h0020, 16'h0011};

        for (int t = 0; t < 4096; t++)
            for (int k = 0; k < 8; k++) begin
                mem_line[t][16*k +: 16] = pat_word(12'(t), k);
                ref_mem[t*8 + k]        = pat_word(12'(t), k);
            end
        m_valid = 1'b0;
        m_dirty = 1'b0;
        m_tag   = '0;

        rst_n = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_byte_enable = '0;
        mem_address = '0;
        mem_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_resp", mem_resp, 1'b0);
        check("rst_mem_rdata", mem_rdata, 16'h0000);
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_pmem_address", pmem_address, 16'h0000);
        check("rst_pmem_wdata", pmem_wdata, 128'h0);
        rst_n = 1'b1;

        delay_mem = 1;
        for (int i = 0; i < 13; i++) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be, 1'b0, got, lat, drd, dwr);
            exp_lat = tbl[i].exp_hit ? 2 : (tbl[i].exp_wb ? 2*delay_mem + 5 : delay_mem + 3);
            check($sformatf("row%0d_latency", i), lat, exp_lat);
            check($sformatf("row%0d_fills", i), drd, tbl[i].exp_hit ? 0 : 1);
            check($sformatf("row%0d_wbs", i), dwr, tbl[i].exp_wb ? 1 : 0);
            if (tbl[i].exp_wb)   check($sformatf("row%0d_wb_addr", i), last_wb_addr, tbl[i].wb_addr);
            if (!tbl[i].exp_hit) check($sformatf("row%0d_fill_addr", i), last_fill_addr, tbl[i].fill_addr);
            if (!tbl[i].wr)      check($sformatf("row%0d_rdata", i), got, tbl[i].exp_rdata);
            model_update(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be);
        end

        // Reset in the middle of a slow fill: request drops at once, next access misses cleanly.
        delay_mem = 6;
        run_model(1'b1, 1'b0, 16'h2000, 16'h0000, 2'b11, 1'b0);
        drd = n_rd;
        @(negedge clk);
        mem_read = 1'b1;
        mem_address = 16'h1000;
        @(negedge clk);
        @(negedge clk);
        check("midfill_pmem_read", pmem_read, 1'b1);
        check("midfill_pmem_addr", pmem_address, 16'h1000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midfill_rst_read", pmem_read, 1'b0);
        check("midfill_rst_addr", pmem_address, 16'h0000);
        check("midfill_rst_resp", mem_resp, 1'b0);
        mem_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("midfill_abandoned", n_rd - drd, 0);
        run_model(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, 1'b0);

        // Dirty data held only in the buffer is lost across reset.
        delay_mem = 0;
        run_model(1'b0, 1'b1, 16'h0040, 16'hCAFE, 2'b11, 1'b0);
        apply_reset();
        run_model(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b11, 1'b0);
        check("dirty_lost", ref_mem[16'h0040 >> 1], 16'h0030);

        // CPU keeps its request up through RESPOND.
        delay_mem = 3;
        run_model(1'b1, 1'b0, 16'h0050, 16'h0000, 2'b11, 1'b1);
        run_model(1'b0, 1'b1, 16'h0052, 16'h7788, 2'b11, 1'b1);
        run_model(1'b1, 1'b0, 16'h0060, 16'h0000, 2'b11, 1'b1);

        for (int i = 0; i < 300; i++) begin
            delay_mem = $urandom_range(0, 3);
            case ($urandom_range(0, 4))
                0: a[15:4] = 12'h000;
                1: a[15:4] = 12'h001;
                2: a[15:4] = 12'h002;
                3: a[15:4] = 12'h003;
                default: a[15:4] = 12'hFFF;
            endcase
            a[3:0] = 4'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            r = w ? ($urandom_range(0, 7) == 0) : 1'b1;
            run_model(r, w, a, 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
